// File: rtl/wm8731_adc_rx.sv
// WM8731 ADC receiver, I2S mode with the codec as bit/frame clock master.
// The codec pins are synchronized into clk_50m and sampled on bit-clock rises.
// Each complete left+right frame is presented as one parallel stereo sample.
`timescale 1ns/1ps
module wm8731_adc_rx #(
  parameter int WL       = 32,
  parameter int SYNC_LEN = 2
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          cfg_done,
  input  logic          aud_bclk,
  input  logic          aud_adclrc,
  input  logic          aud_adcdat,
  output logic [WL-1:0] rx_data_l,
  output logic [WL-1:0] rx_data_r,
  output logic          rx_valid,
  output logic          rx_err
);

  localparam int CNT_W = $clog2(WL + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [SYNC_LEN-1:0] bclk_sync;
  logic [SYNC_LEN-1:0] lrc_sync;
  logic [SYNC_LEN-1:0] dat_sync;
  logic                bclk_s;
  logic                lrc_s;
  logic                dat_s;
  logic                bclk_prev;
  logic                lrc_q;
  logic                bre;
  logic                ch_edge;
  logic                left_start;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WL-1:0]       shift_reg;
  logic [WL-1:0]       left_hold;
  logic [WL-1:0]       word_next;
  logic                left_ok;
  logic                vld_p1;
  logic                shift_en;
  logic                word_done;
  logic                short_edge;

  // Three identical synchronizer chains keep bclk, lrc and dat mutually aligned
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_LEN-2:0], aud_bclk};
      lrc_sync  <= {lrc_sync[SYNC_LEN-2:0], aud_adclrc};
      dat_sync  <= {dat_sync[SYNC_LEN-2:0], aud_adcdat};
    end
  end

  assign bclk_s = bclk_sync[SYNC_LEN-1];
  assign lrc_s  = lrc_sync[SYNC_LEN-1];
  assign dat_s  = dat_sync[SYNC_LEN-1];

  // Bit-clock edge detector and the LRC level seen at the previous bit-clock rise
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      bclk_prev <= 1'b0;
      lrc_q     <= 1'b0;
    end else begin
      bclk_prev <= bclk_s;
      if (bre) begin
        lrc_q <= lrc_s;
      end
    end
  end

  assign bre        = bclk_s & ~bclk_prev;
  assign ch_edge    = bre & (lrc_s ^ lrc_q);
  assign left_start = ch_edge & ~lrc_s;
  assign word_next  = {shift_reg[WL-2:0], dat_s};

  // Capture FSM state register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the per-bit qualifiers; the channel-edge rise is the I2S delay slot
  always_comb begin
    state_nx   = state;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    short_edge = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_done) begin
          state_nx = ARM;
        end
      end
      ARM: begin
        if (!cfg_done) begin
          state_nx = IDLE;
        end else if (left_start) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (!cfg_done) begin
          state_nx = IDLE;
        end else if (ch_edge) begin
          short_edge = (bit_cnt != CNT_FULL);
        end else if (bre && (bit_cnt < CNT_FULL)) begin
          shift_en  = 1'b1;
          word_done = (bit_cnt == CNT_LAST);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Data-bit counter: cleared outside SHIFT and at every channel edge, saturates at WL
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if ((state != SHIFT) || !cfg_done || ch_edge) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Frame bookkeeping: left word held until its right partner completes, short channels flag an error
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      left_ok <= 1'b0;
      vld_p1  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      vld_p1 <= word_done & lrc_s & left_ok;
      if (short_edge) begin
        rx_err <= 1'b1;
      end
      if ((state != SHIFT) || !cfg_done) begin
        left_ok <= 1'b0;
      end else if (ch_edge) begin
        if (short_edge || !lrc_s) begin
          left_ok <= 1'b0;
        end
      end else if (word_done) begin
        left_ok <= ~lrc_s;
      end
    end
  end

  // Serial-to-parallel shift register and left holding register
  always_ff @(posedge clk_50m) begin
    if (shift_en) begin
      shift_reg <= word_next;
    end
    if (word_done && !lrc_s) begin
      left_hold <= word_next;
    end
  end

  // Output stage: stereo pair loads one cycle after the right word completes
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_l <= '0;
      rx_data_r <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= vld_p1;
      if (vld_p1) begin
        rx_data_l <= left_hold;
        rx_data_r <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_wm8731_adc_rx.sv
// Bench for wm8731_adc_rx: drives I2S frames as the codec would and compares
// received stereo pairs against a channel-level model of the capture rules.
`timescale 1ns/1ps
module tb_wm8731_adc_rx;

  localparam int WL = 32;

  logic          clk_50m    = 1'b0;
  logic          rst_n      = 1'b0;
  logic          cfg_done   = 1'b0;
  logic          aud_bclk   = 1'b0;
  logic          aud_adclrc = 1'b1;
  logic          aud_adcdat = 1'b0;
  logic [WL-1:0] rx_data_l;
  logic [WL-1:0] rx_data_r;
  logic          rx_valid;
  logic          rx_err;

  int checks = 0;
  int errors = 0;

  always #10 clk_50m = ~clk_50m;

  wm8731_adc_rx #(.WL(WL), .SYNC_LEN(2)) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .cfg_done  (cfg_done),
    .aud_bclk  (aud_bclk),
    .aud_adclrc(aud_adclrc),
    .aud_adcdat(aud_adcdat),
    .rx_data_l (rx_data_l),
    .rx_data_r (rx_data_r),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err)
  );

  // Reference model state, tracked per channel
  bit            m_cfg   = 0;
  bit            m_armed = 0;
  bit            m_lpend = 0;
  bit            m_err   = 0;
  int            m_len   = 0;
  logic [WL-1:0] m_left  = '0;
  logic [WL-1:0] m_word  = '0;
  logic [2*WL-1:0] exp_q[$];
  logic [2*WL-1:0] got_q[$];

  // Output monitor
  int            chg_cnt = 0;
  int            dbl_cnt = 0;
  logic [WL-1:0] prev_l  = '0;
  logic [WL-1:0] prev_r  = '0;
  logic          prev_v  = 1'b0;

  always @(negedge clk_50m) begin
    if (rst_n) begin
      if (rx_valid) got_q.push_back({rx_data_l, rx_data_r});
      if (rx_valid && prev_v) dbl_cnt <= dbl_cnt + 1;
      if (!rx_valid && ((rx_data_l !== prev_l) || (rx_data_r !== prev_r))) chg_cnt <= chg_cnt + 1;
    end
    prev_l <= rx_data_l;
    prev_r <= rx_data_r;
    prev_v <= rx_valid;
  end

  task automatic set_cfg(input bit v);
    cfg_done = v;
    m_cfg    = v;
    if (!v) begin
      m_armed = 0;
      m_lpend = 0;
    end
  endtask

  task automatic model_reset();
    m_armed = 0;
    m_lpend = 0;
    m_err   = 0;
  endtask

  // A new channel begins: judge the finished one, a left start aligns capture
  task automatic model_edge(input bit lr);
    if (m_armed && (m_len < WL + 1)) begin
      m_err   = 1;
      m_lpend = 0;
    end
    m_len = 0;
    if (!lr) begin
      m_lpend = 0;
      if (m_cfg) m_armed = 1;
    end
  endtask

  // One bit-clock rise: the slot plus WL data bits completes a word
  task automatic model_bit(input bit lr);
    m_len++;
    if (m_armed && (m_len == WL + 1)) begin
      if (!lr) begin
        m_left  = m_word;
        m_lpend = 1;
      end else if (m_lpend) begin
        exp_q.push_back({m_left, m_word});
        m_lpend = 0;
      end
    end
  endtask

  // Codec side: lrc and data change on the falling edge, MSB one rise after the LRC change
  task automatic send_channel(input bit lr, input logic [WL-1:0] w, input int n,
                              input int hp, input int cfg_at);
    m_word = w;
    for (int i = 0; i < n; i++) begin
      aud_bclk = 1'b0;
      if (i == cfg_at) set_cfg(1);
      if ((i == 0) && (aud_adclrc != lr)) begin
        model_edge(lr);
        aud_adclrc = lr;
      end
      if ((i >= 1) && (i <= WL)) aud_adcdat = w[WL-i];
      else aud_adcdat = 1'($urandom_range(0, 1));
      #hp;
      aud_bclk = 1'b1;
      model_bit(lr);
      #hp;
    end
  endtask

  task automatic send_frame(input logic [WL-1:0] l, input logic [WL-1:0] r,
                            input int nl, input int nr, input int hp);
    send_channel(1'b0, l, nl, hp, -1);
    send_channel(1'b1, r, nr, hp, -1);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk_50m);
    #5;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50m);
    #5;
    checks++; if (rx_data_l !== '0) begin errors++; $display("FAIL reset_data_l got=%h exp=0", rx_data_l); end
    checks++; if (rx_data_r !== '0) begin errors++; $display("FAIL reset_data_r got=%h exp=0", rx_data_r); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rx_err); end
    rst_n = 1'b1;
    model_reset();
    settle();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_basic();
    exp_q.delete(); got_q.delete();
    set_cfg(1);
    settle();
    send_channel(1'b1, '0, 4, 163, -1);
    for (int f = 0; f < 3; f++) send_frame(32'h8000_0001, 32'h7FFF_FFFE, 33, 33, 163);
    settle();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_model_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {32'h8000_0001, 32'h7FFF_FFFE}) begin
        errors++; $display("FAIL basic_pair[%0d] got=%h exp=80000001_7ffffffe", i, got_q[i]);
      end
    end
    checks++; if (rx_err !== m_err) begin errors++; $display("FAIL basic_err got=%b exp=%b", rx_err, m_err); end
  endtask

  task automatic test_cfg_gate();
    logic [WL-1:0] l, r;
    exp_q.delete(); got_q.delete();
    set_cfg(0);
    for (int f = 0; f < 3; f++) send_frame(WL'($urandom), WL'($urandom), 33, 33, 163);
    settle();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL gate_off_count got=%0d exp=0", got_q.size()); end
    send_channel(1'b0, WL'($urandom), 33, 163, -1);
    send_channel(1'b1, WL'($urandom), 33, 163, 15);
    l = WL'($urandom);
    r = WL'($urandom);
    send_frame(l, r, 33, 33, 163);
    settle();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL gate_on_count got=%0d exp=1", got_q.size()); end
    checks++; if (exp_q.size() !== 1) begin errors++; $display("FAIL gate_model_count got=%0d exp=1", exp_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== {l, r}) begin errors++; $display("FAIL gate_pair got=%h exp=%h", got_q[0], {l, r}); end
    end
  endtask

  task automatic test_short_channel();
    logic [WL-1:0] l, r;
    exp_q.delete(); got_q.delete();
    send_channel(1'b0, WL'($urandom), 21, 163, -1);
    send_channel(1'b1, WL'($urandom), 33, 163, -1);
    settle();
    checks++; if (rx_err !== 1'b1) begin errors++; $display("FAIL short_err got=%b exp=1", rx_err); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL short_count got=%0d exp=0", got_q.size()); end
    l = WL'($urandom);
    r = WL'($urandom);
    send_frame(l, r, 33, 33, 163);
    settle();
    checks++; if (rx_err !== m_err) begin errors++; $display("FAIL short_err_sticky got=%b exp=%b", rx_err, m_err); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL short_model_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== {l, r}) begin errors++; $display("FAIL short_recover_pair got=%h exp=%h", got_q[0], {l, r}); end
    end
  endtask

  task automatic test_long_channel();
    logic [WL-1:0] r;
    exp_q.delete(); got_q.delete();
    r = WL'($urandom);
    send_frame(32'h1234_5678, r, 34, 34, 163);
    send_frame(32'h1234_5678, r, 34, 34, 163);
    settle();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL long_count got=%0d exp=2", got_q.size()); end
    checks++; if (rx_data_l !== 32'h1234_5678) begin errors++; $display("FAIL long_data_l got=%h exp=12345678", rx_data_l); end
    checks++; if (rx_data_r !== r) begin errors++; $display("FAIL long_data_r got=%h exp=%h", rx_data_r, r); end
  endtask

  task automatic test_reset_mid();
    logic [WL-1:0] l, r;
    exp_q.delete(); got_q.delete();
    send_channel(1'b0, WL'($urandom), 33, 163, -1);
    send_channel(1'b1, WL'($urandom), 10, 163, -1);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rx_data_l !== '0) begin errors++; $display("FAIL rstmid_data_l got=%h exp=0", rx_data_l); end
    checks++; if (rx_data_r !== '0) begin errors++; $display("FAIL rstmid_data_r got=%h exp=0", rx_data_r); end
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", rx_err); end
    repeat (3) @(posedge clk_50m);
    #3;
    rst_n = 1'b1;
    send_channel(1'b1, WL'($urandom), 23, 163, -1);
    for (int f = 0; f < 2; f++) begin
      l = WL'($urandom);
      r = WL'($urandom);
      send_frame(l, r, 33, 33, 163);
    end
    settle();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL rstmid_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_pair[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    exp_q.delete(); got_q.delete();
    for (int f = 0; f < 150; f++) begin
      send_frame(WL'($urandom), WL'($urandom), 33 + int'($urandom_range(0, 1)),
                 33 + int'($urandom_range(0, 1)), 40);
    end
    settle();
    checks++; if (got_q.size() !== 150) begin errors++; $display("FAIL rand_count got=%0d exp=150", got_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_model_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pair[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rx_err !== m_err) begin errors++; $display("FAIL rand_err got=%b exp=%b", rx_err, m_err); end
    checks++; if (chg_cnt !== 0) begin errors++; $display("FAIL data_hold changes=%0d exp=0", chg_cnt); end
    checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL valid_width long_pulses=%0d exp=0", dbl_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_gate();
    test_short_channel();
    test_long_channel();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
